uart_alu_pkt_tx: RTL and testbench

Parametrised command-packet serialiser for the UART ALU link. It takes one command (opcode plus word count) and a stream of operand words of WORD_WIDTH bits. It emits the framed byte stream on an AXI-stream byte interface that feeds uart_tx. Frame layout: opcode, reserved 0x00, length LSB, length MSB, then the payload words, each sent LSB-byte first.

---
 rtl/uart_alu_pkt_tx_if.sv | 35 +++
 rtl/uart_alu_pkt_tx.sv | 156 +++++++++++++++
 tb/tb_uart_alu_pkt_tx.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkt_tx_if.sv
// Command, operand-word and output byte-stream bundle for uart_alu_pkt_tx.
// master = packet source / byte sink side, slave = the serialiser itself.
interface uart_alu_pkt_tx_if #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WORDS  = 16,
  parameter int CNT_W      = $clog2(MAX_WORDS + 1)
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [7:0]            cmd_opcode_i;
  logic [CNT_W-1:0]      cmd_nwords_i;
  logic                  s_word_valid_i;
  logic                  s_word_ready_o;
  logic [WORD_WIDTH-1:0] s_word_data_i;
  logic [7:0]            m_axis_tdata_o;
  logic                  m_axis_tvalid_o;
  logic                  m_axis_tready_i;
  logic                  m_axis_tlast_o;
  logic                  busy_o;
  logic                  err_o;

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_nwords_i, s_word_valid_i, s_word_data_i,
           m_axis_tready_i,
    input  cmd_ready_o, s_word_ready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
           busy_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_nwords_i, s_word_valid_i, s_word_data_i,
           m_axis_tready_i,
    output cmd_ready_o, s_word_ready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
           busy_o, err_o
  );
endinterface

// File: rtl/uart_alu_pkt_tx.sv
// UART ALU command-packet serialiser: opcode, 0x00, LEN lo/hi, payload words LSB-byte first.
// Optional trailing XOR checksum byte when UART_ALU_PKT_CHECKSUM_EN is defined.
module uart_alu_pkt_tx #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WORDS  = 16,
  parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input logic              clk_i,
  input logic              rst_ni,
  uart_alu_pkt_tx_if.slave bus
);
  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
`ifdef UART_ALU_PKT_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  // state  | meaning
  // IDLE   | wait for command | OP/RSV/LEN_LO/LEN_HI header bytes
  // LOAD   | fetch next word  | PAY payload bytes | CSUM checksum byte
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OP     = 3'd1,
    RSV    = 3'd2,
    LEN_LO = 3'd3,
    LEN_HI = 3'd4,
    LOAD   = 3'd5,
    PAY    = 3'd6
`ifdef UART_ALU_PKT_CHECKSUM_EN
    , CSUM = 3'd7
`endif
  } state_t;

`ifdef UART_ALU_PKT_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] csum_q;
`else
  localparam state_t TAIL = IDLE;
`endif

  state_t                state_q, state_d;
  logic [7:0]            opcode_q;
  logic [CNT_W-1:0]      words_left_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  cmd_ready_q, err_q;
  logic                  cmd_hs, cmd_ok, word_hs, byte_hs, word_end, last_word;
  logic [15:0]           frame_len;
  logic [7:0]            tdata;
  logic                  tvalid, tlast;

  assign cmd_hs    = bus.cmd_valid_i && cmd_ready_q;
  assign cmd_ok    = bus.cmd_nwords_i <= CNT_W'(MAX_WORDS);
  assign word_hs   = bus.s_word_valid_i && (state_q == LOAD);
  assign byte_hs   = tvalid && bus.m_axis_tready_i;
  assign word_end  = idx_q == IDX_W'(WORD_BYTES - 1);
  assign last_word = words_left_q == CNT_W'(1);
  // words_left_q still holds the full word count throughout the header
  assign frame_len = 16'(4 + CSUM_BYTES) + 16'(words_left_q) * 16'(WORD_BYTES);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (cmd_hs && cmd_ok) state_d = OP;
      OP:     if (byte_hs) state_d = RSV;
      RSV:    if (byte_hs) state_d = LEN_LO;
      LEN_LO: if (byte_hs) state_d = LEN_HI;
      LEN_HI: if (byte_hs) state_d = (words_left_q == '0) ? TAIL : LOAD;
      LOAD:   if (word_hs) state_d = PAY;
      PAY:    if (byte_hs && word_end) state_d = last_word ? TAIL : LOAD;
`ifdef UART_ALU_PKT_CHECKSUM_EN
      CSUM:   if (byte_hs) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tvalid = 1'b0;
    tdata  = 8'h00;
    tlast  = 1'b0;
    case (state_q)
      OP:     begin tvalid = 1'b1; tdata = opcode_q; end
      RSV:    tvalid = 1'b1;
      LEN_LO: begin tvalid = 1'b1; tdata = frame_len[7:0]; end
      LEN_HI: begin
        tvalid = 1'b1;
        tdata  = frame_len[15:8];
`ifndef UART_ALU_PKT_CHECKSUM_EN
        tlast  = words_left_q == '0;
`endif
      end
      PAY: begin
        tvalid = 1'b1;
        tdata  = word_q[7:0];
`ifndef UART_ALU_PKT_CHECKSUM_EN
        tlast  = word_end && last_word;
`endif
      end
`ifdef UART_ALU_PKT_CHECKSUM_EN
      CSUM:   begin tvalid = 1'b1; tdata = csum_q; tlast = 1'b1; end
`endif
      default: ;
    endcase
  end

  // cmd_ready follows the next state, so it is registered yet already high on entering IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready_q  <= 1'b0;
      err_q        <= 1'b0;
      opcode_q     <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      idx_q        <= '0;
    end else begin
      cmd_ready_q <= state_d == IDLE;
      err_q       <= cmd_hs && !cmd_ok;
      if (cmd_hs && cmd_ok) begin
        opcode_q     <= bus.cmd_opcode_i;
        words_left_q <= bus.cmd_nwords_i;
      end
      if (word_hs) begin
        word_q <= bus.s_word_data_i;
        idx_q  <= '0;
      end else if (byte_hs && state_q == PAY) begin
        word_q <= word_q >> 8;
        idx_q  <= idx_q + IDX_W'(1);
        if (word_end) words_left_q <= words_left_q - CNT_W'(1);
      end
    end
  end

`ifdef UART_ALU_PKT_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      csum_q <= '0;
    else if (cmd_hs)  csum_q <= '0;
    else if (byte_hs) csum_q <= csum_q ^ tdata;
  end
`endif

  assign bus.cmd_ready_o     = cmd_ready_q;
  assign bus.s_word_ready_o  = state_q == LOAD;
  assign bus.m_axis_tdata_o  = tdata;
  assign bus.m_axis_tvalid_o = tvalid;
  assign bus.m_axis_tlast_o  = tlast;
  assign bus.busy_o          = state_q != IDLE;
  assign bus.err_o           = err_q;
endmodule

// File: tb/tb_uart_alu_pkt_tx.sv
// Bench for uart_alu_pkt_tx: queue-based frame model checked every cycle plus literal frames.
module tb_uart_alu_pkt_tx;
  localparam int WW = 32;
  localparam int MW = 16;
  localparam int CW = $clog2(MW + 1);
  localparam int WB = WW / 8;
`ifdef UART_ALU_PKT_CHECKSUM_EN
  localparam int CSB = 1;
`else
  localparam int CSB = 0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ent_t       exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] lit_q[$];
  logic       in_pkt = 1'b0;
  int         owed = 0;
  logic       err_pend = 1'b0;
  logic       skip_ready = 1'b1;
  logic [7:0] run_xor = 8'h00;
  int         err_cnt = 0;
  logic       bp_en = 1'b0;
  int         bp_ph = 0;

  uart_alu_pkt_tx_if #(.WORD_WIDTH(WW), .MAX_WORDS(MW), .CNT_W(CW)) bus ();

  uart_alu_pkt_tx #(.WORD_WIDTH(WW), .MAX_WORDS(MW), .CNT_W(CW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_q.push_back(ent_t'({d, 1'b0}));
    run_xor = run_xor ^ d;
  endtask

  task automatic close_frame();
`ifdef UART_ALU_PKT_CHECKSUM_EN
    exp_q.push_back(ent_t'({run_xor, 1'b1}));
`else
    exp_q[exp_q.size() - 1].l = 1'b1;
`endif
  endtask

  // tready pattern 1,0,0,1 when backpressure is enabled
  always @(posedge clk_i) begin
    #1;
    if (bp_en) begin
      bus.m_axis_tready_i = (bp_ph % 4 == 0) || (bp_ph % 4 == 3);
      bp_ph++;
    end else begin
      bus.m_axis_tready_i = 1'b1;
    end
  end

  // Model: bytes become expected when the command/word carrying them is accepted.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      in_pkt     = 1'b0;
      owed       = 0;
      err_pend   = 1'b0;
      skip_ready = 1'b1;
    end else begin
      chk("tvalid", 32'(bus.m_axis_tvalid_o), 32'(exp_q.size() != 0));
      if (bus.m_axis_tvalid_o && exp_q.size() != 0) begin
        chk("tdata", 32'(bus.m_axis_tdata_o), 32'(exp_q[0].d));
        chk("tlast", 32'(bus.m_axis_tlast_o), 32'(exp_q[0].l));
      end
      chk("s_word_ready", 32'(bus.s_word_ready_o), 32'(exp_q.size() == 0 && owed > 0));
      chk("busy", 32'(bus.busy_o), 32'(in_pkt));
      if (!skip_ready) chk("cmd_ready", 32'(bus.cmd_ready_o), 32'(!in_pkt));
      skip_ready = 1'b0;
      chk("err", 32'(bus.err_o), 32'(err_pend));
      if (bus.err_o) err_cnt++;
      err_pend = 1'b0;

      if (bus.m_axis_tvalid_o && bus.m_axis_tready_i && exp_q.size() != 0) begin
        got_q.push_back(bus.m_axis_tdata_o);
        if (exp_q[0].l) in_pkt = 1'b0;
        void'(exp_q.pop_front());
      end
      if (bus.cmd_valid_i && bus.cmd_ready_o) begin
        if (int'(bus.cmd_nwords_i) > MW) begin
          err_pend = 1'b1;
        end else begin
          logic [15:0] len;
          len     = 16'(4 + int'(bus.cmd_nwords_i) * WB + CSB);
          in_pkt  = 1'b1;
          owed    = int'(bus.cmd_nwords_i);
          run_xor = 8'h00;
          push_byte(bus.cmd_opcode_i);
          push_byte(8'h00);
          push_byte(len[7:0]);
          push_byte(len[15:8]);
          if (owed == 0) close_frame();
        end
      end
      if (bus.s_word_valid_i && bus.s_word_ready_o) begin
        for (int i = 0; i < WB; i++) push_byte(bus.s_word_data_i[8*i +: 8]);
        owed--;
        if (owed == 0) close_frame();
      end
    end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [CW-1:0] nw);
    bit done;
    done = 1'b0;
    @(posedge clk_i); #1;
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_opcode_i = op;
    bus.cmd_nwords_i = nw;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      if (bus.cmd_ready_o) done = 1'b1;
    end
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    chk("cmd_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    bit done;
    done = 1'b0;
    @(posedge clk_i); #1;
    bus.s_word_valid_i = 1'b1;
    bus.s_word_data_i  = w;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      if (bus.s_word_ready_o) done = 1'b1;
    end
    @(posedge clk_i); #1;
    bus.s_word_valid_i = 1'b0;
    chk("word_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((in_pkt || exp_q.size() != 0) && n < 3000);
    chk("packet_done_timeout", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_nbytes"}, 32'(got_q.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
      chk({nm, "_byte"}, 32'(got_q[i]), 32'(lit_q[i]));
  endtask

  task automatic run_echo(input string nm);
    got_q.delete();
    send_cmd(8'hEC, CW'(1));
    send_word(32'hDEADBEEF);
    wait_done();
`ifdef UART_ALU_PKT_CHECKSUM_EN
    lit_q = '{8'hEC, 8'h00, 8'h09, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC7};
`else
    lit_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
    check_frame(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd0);
    chk({nm, "_s_word_ready"}, 32'(bus.s_word_ready_o), 32'd0);
    chk({nm, "_tvalid"}, 32'(bus.m_axis_tvalid_o), 32'd0);
    chk({nm, "_tdata"}, 32'(bus.m_axis_tdata_o), 32'd0);
    chk({nm, "_tlast"}, 32'(bus.m_axis_tlast_o), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({nm, "_err"}, 32'(bus.err_o), 32'd0);
  endtask

  initial begin
    int e0, n;
    bus.cmd_valid_i    = 1'b0;
    bus.cmd_opcode_i   = 8'h00;
    bus.cmd_nwords_i   = '0;
    bus.s_word_valid_i = 1'b0;
    bus.s_word_data_i  = '0;

    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_before_first_edge", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk_i);
    chk("ready_after_first_edge", 32'(bus.cmd_ready_o), 32'd1);

    run_echo("echo");

    // empty packet, with a word offered the whole time that must never be taken
    got_q.delete();
    bus.s_word_valid_i = 1'b1;
    bus.s_word_data_i  = 32'h12345678;
    send_cmd(8'h01, CW'(0));
    wait_done();
    bus.s_word_valid_i = 1'b0;
`ifdef UART_ALU_PKT_CHECKSUM_EN
    lit_q = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h04};
`else
    lit_q = '{8'h01, 8'h00, 8'h04, 8'h00};
`endif
    check_frame("empty");

    bp_en = 1'b1;
    run_echo("backpressure");
    bp_en = 1'b0;

    // word starvation: second word arrives 20 cycles late
    got_q.delete();
    send_cmd(8'h22, CW'(2));
    send_word(32'h11223344);
    repeat (20) @(posedge clk_i);
    send_word(32'h55667788);
    wait_done();
`ifdef UART_ALU_PKT_CHECKSUM_EN
    lit_q = '{8'h22, 8'h00, 8'h0D, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
              8'h88, 8'h77, 8'h66, 8'h55, 8'hA7};
`else
    lit_q = '{8'h22, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
              8'h88, 8'h77, 8'h66, 8'h55};
`endif
    check_frame("starvation");

    // largest accepted packet
    got_q.delete();
    send_cmd(8'h55, CW'(MW));
    for (int i = 0; i < MW; i++) send_word(32'(i) * 32'h01010101);
    wait_done();
    chk("max_nbytes", 32'(got_q.size()), 32'(4 + MW * WB + CSB));
    if (got_q.size() > 3) begin
      chk("max_len_lo", 32'(got_q[2]), 32'(68 + CSB));
      chk("max_len_hi", 32'(got_q[3]), 32'd0);
    end

    // oversize command is rejected with a single err pulse and no bytes
    got_q.delete();
    e0 = err_cnt;
    send_cmd(8'h33, CW'(MW + 1));
    repeat (5) @(negedge clk_i);
    chk("oversize_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("oversize_nbytes", 32'(got_q.size()), 32'd0);
    run_echo("after_oversize");

    // reset in the middle of the payload
    got_q.delete();
    send_cmd(8'h44, CW'(2));
    send_word(32'hCAFEF00D);
    n = 0;
    while (got_q.size() < 5 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("mid_payload_reach", 32'(got_q.size() >= 5), 32'd1);
    @(posedge clk_i); #3 rst_ni = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("no_resume_after_reset", 32'(bus.m_axis_tvalid_o), 32'd0);
    run_echo("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
